inbuf_ctrl: RTL and testbench
=============================

Name: inbuf_ctrl

Overview:
- Ring-buffer controller for the UART input path. It sits between the UART byte receiver and the existing 4096-bit dual-port BRAM (WIDTH=8, 512 entries).
- The block drives the BRAM write port from incoming bytes and drives the BRAM read port.
- It presents the oldest byte to the CPU I/O unit as a registered first-word-fall-through output with a pop handshake.

Parameters:
- WIDTH, 8, byte width; must match the BRAM WIDTH.
- DEPTH, 512, entries (4096/WIDTH).
- ADDRW, $clog2(DEPTH) = 9, BRAM address width.

Ports:
- clk_in  input  1  system clock; all logic is on the rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- rx_valid_in  input  1  one-cycle strobe: rx_data_in holds a received byte.
- rx_data_in  input  WIDTH  received byte.
- pop_in  input  1  consumer has taken data_out; ignored while valid_out=0.
- clr_ovf_in  input  1  clears overflow_out.
- data_out  output  WIDTH  oldest unconsumed byte, registered.
- valid_out  output  1  data_out is valid.
- count_out  output  ADDRW+1  bytes held in BRAM, excluding the byte in data_out.
- full_out  output  1  count_out == DEPTH.
- overflow_out  output  1  sticky flag: a byte was dropped because the buffer was full.
- ram_wen_out  output  1  BRAM write enable.
- ram_waddr_out  output  ADDRW  BRAM write address.
- ram_wdata_out  output  WIDTH  BRAM write data.
- ram_raddr_out  output  ADDRW  BRAM read address.
- ram_rdata_in  input  WIDTH  BRAM registered read data (1-cycle latency).

Behaviour:
- Pointers: wr_ptr and rd_ptr are ADDRW+1 bits wide, with the extra wrap bit.
  - count = wr_ptr - rd_ptr, computed modulo 2^(ADDRW+1).
  - Empty when the pointers are equal; full when count == DEPTH.
  - Wrap from 511 to 0 is natural through the low ADDRW bits.
- Reset (asynchronous assert, synchronous deassert at the parent):
  - wr_ptr = rd_ptr = 0, state IDLE.
  - valid_out = 0, data_out = 0, overflow_out = 0, ram_wen_out = 0.
  - BRAM contents are not cleared; a reset mid-stream discards all buffered bytes, including data_out.
- Write path (combinational to the BRAM):
  - ram_wen_out = rx_valid_in & ~full.
  - ram_waddr_out = wr_ptr[ADDRW-1:0]; ram_wdata_out = rx_data_in.
  - wr_ptr increments on the same edge as the write.
  - rx_valid_in while full: byte is dropped, wr_ptr is unchanged, overflow_out is set on the next edge.
  - overflow_out clears only via clr_ovf_in. If a drop and clr_ovf_in coincide, set wins.
- Read path:
  - ram_raddr_out = rd_ptr[ADDRW-1:0] at all times, driven from a register.
  - The BRAM has no read-during-write check, so the controller never consumes a read of an address written on the same edge. This holds because the BRAM is only read when the registered pointers differ, and writes are blocked when full.
- FSM:
  - IDLE: valid_out = 0. If wr_ptr != rd_ptr, go to LOAD.
  - LOAD: ram_rdata_in holds mem[rd_ptr]. On the edge: data_out <= ram_rdata_in, rd_ptr++, valid_out <= 1, go to HOLD.
  - HOLD: valid_out = 1.
    - pop_in with wr_ptr != rd_ptr: go to LOAD, valid_out <= 0.
    - pop_in when empty: go to IDLE, valid_out <= 0.
    - No pop_in: stay in HOLD, data_out stable.
- Timing:
  - Latency: byte written at edge E gives valid_out = 1 after edge E+2.
  - Sustained drain rate: one byte per 2 cycles.
- Simultaneous events:
  - A write and a LOAD capture on the same edge update both pointers; count_out reflects both.
  - A write while the buffer is full and a capture frees space on the same edge: the write is still dropped, since full is evaluated from the pre-edge pointers.
- count_out and full_out are derived combinationally from the registered pointers.

Decomposition:
- Package inbuf_pkg holds:
  - localparams INBUF_WIDTH = 8, INBUF_DEPTH = 512, INBUF_ADDRW = 9;
  - typedef enum logic [1:0] {IDLE, LOAD, HOLD} inbuf_state_t;
  - typedef logic [INBUF_ADDRW:0] inbuf_ptr_t.
- No sub-module inside the controller. The parent io_inbuf top instantiates inbuf_ctrl and the dual-port BRAM and wires them 1:1; the bench uses the same pairing.

Test Plan:
- Reset, then a single byte: rx 0x41 at cycle 5 -> valid_out = 1, data_out = 0x41 at cycle 7, count_out = 0. Pop -> valid_out = 0, state IDLE.
- Burst, no pop: 10 bytes 0x00..0x09 back-to-back -> data_out = 0x00, count_out = 9. Pop every cycle -> bytes come out in order, one per 2 cycles, ending empty.
- Fill to full: 513 writes with no pop -> 1 byte in data_out, 512 in BRAM, full_out = 1.
  - 514th write -> dropped, overflow_out = 1, count_out stays 512.
  - clr_ovf_in -> overflow_out = 0.
- Wrap-around: push and pop 1500 bytes of pattern (i*7) mod 256 with random gaps -> every output matches, no loss or duplication, pointers wrap cleanly.
- Write and pop on the same edge while count = 1 -> count_out stays 1 and ordering is preserved.
- Async reset asserted mid-burst, between clock edges -> outputs reset immediately with no clock needed. After release, new byte 0x55 appears alone with count_out = 0.

Source files
------------

// File: rtl/inbuf_pkg.sv
// Shared types and sizing for the UART input ring-buffer controller.
package inbuf_pkg;

  localparam int INBUF_WIDTH = 8;
  localparam int INBUF_DEPTH = 512;
  localparam int INBUF_ADDRW = 9;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    HOLD
  } inbuf_state_t;

  typedef logic [INBUF_ADDRW:0] inbuf_ptr_t;

endpackage

// File: rtl/inbuf_ctrl.sv
// Ring-buffer controller between the UART receiver and a registered-read BRAM,
// presenting the oldest byte as a registered first-word-fall-through output.
module inbuf_ctrl
  import inbuf_pkg::*;
#(
  parameter int WIDTH = INBUF_WIDTH,
  parameter int DEPTH = INBUF_DEPTH,
  parameter int ADDRW = $clog2(DEPTH)
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rx_valid_in,
  input  logic [WIDTH-1:0] rx_data_in,
  input  logic             pop_in,
  input  logic             clr_ovf_in,
  output logic [WIDTH-1:0] data_out,
  output logic             valid_out,
  output logic [ADDRW:0]   count_out,
  output logic             full_out,
  output logic             overflow_out,
  output logic             ram_wen_out,
  output logic [ADDRW-1:0] ram_waddr_out,
  output logic [WIDTH-1:0] ram_wdata_out,
  output logic [ADDRW-1:0] ram_raddr_out,
  input  logic [WIDTH-1:0] ram_rdata_in
);

  localparam logic [ADDRW:0] FullCount = (ADDRW + 1)'(DEPTH);
  localparam logic [ADDRW:0] PtrOne    = (ADDRW + 1)'(1);

  logic [ADDRW:0]   wrPtr_q, wrPtr_d;
  logic [ADDRW:0]   rdPtr_q, rdPtr_d;
  logic [WIDTH-1:0] data_q, data_d;
  logic             valid_q, valid_d;
  logic             ovf_q, ovf_d;
  inbuf_state_t     state_q, state_d;

  logic [ADDRW:0]   count;
  logic             full;
  logic             notEmpty;
  logic             wrAccept;
  logic             wrDrop;

  // Occupancy comes from the extra wrap bit, so full and empty never alias.
  assign count    = wrPtr_q - rdPtr_q;
  assign full     = (count == FullCount);
  assign notEmpty = (wrPtr_q != rdPtr_q);

  // Writes are held off during reset so the BRAM is never touched while the
  // pointers are being cleared.
  assign wrAccept = rx_valid_in & ~full & rst_n_in;
  assign wrDrop   = rx_valid_in & full;

  always_comb begin
    wrPtr_d = wrPtr_q;
    if (wrAccept) begin
      wrPtr_d = wrPtr_q + PtrOne;
    end
  end

  always_comb begin
    ovf_d = ovf_q;
    if (wrDrop) begin
      ovf_d = 1'b1;
    end else if (clr_ovf_in) begin
      ovf_d = 1'b0;
    end
  end

  // Read-side FSM: the BRAM address already points at rdPtr, so one cycle in
  // LOAD is enough for its registered output to show the oldest byte.
  always_comb begin
    state_d = state_q;
    rdPtr_d = rdPtr_q;
    data_d  = data_q;
    valid_d = valid_q;
    unique case (state_q)
      IDLE: begin
        valid_d = 1'b0;
        if (notEmpty) begin
          state_d = LOAD;
        end
      end
      LOAD: begin
        data_d  = ram_rdata_in;
        rdPtr_d = rdPtr_q + PtrOne;
        valid_d = 1'b1;
        state_d = HOLD;
      end
      HOLD: begin
        valid_d = 1'b1;
        if (pop_in) begin
          valid_d = 1'b0;
          state_d = notEmpty ? LOAD : IDLE;
        end
      end
      default: begin
        valid_d = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      data_q  <= '0;
      valid_q <= 1'b0;
      ovf_q   <= 1'b0;
      state_q <= IDLE;
    end else begin
      wrPtr_q <= wrPtr_d;
      rdPtr_q <= rdPtr_d;
      data_q  <= data_d;
      valid_q <= valid_d;
      ovf_q   <= ovf_d;
      state_q <= state_d;
    end
  end

  assign data_out      = data_q;
  assign valid_out     = valid_q;
  assign count_out     = count;
  assign full_out      = full;
  assign overflow_out  = ovf_q;
  assign ram_wen_out   = wrAccept;
  assign ram_waddr_out = wrPtr_q[ADDRW-1:0];
  assign ram_wdata_out = rx_data_in;
  assign ram_raddr_out = rdPtr_q[ADDRW-1:0];

endmodule

// File: tb/tb_inbuf_ctrl.sv
// Directed bench for inbuf_ctrl paired with a registered-read dual-port BRAM model.
module tb_inbuf_ctrl;

  logic       clk_in;
  logic       rst_n_in;
  logic       rx_valid_in;
  logic [7:0] rx_data_in;
  logic       pop_in;
  logic       clr_ovf_in;
  logic [7:0] data_out;
  logic       valid_out;
  logic [9:0] count_out;
  logic       full_out;
  logic       overflow_out;
  logic       ram_wen_out;
  logic [8:0] ram_waddr_out;
  logic [7:0] ram_wdata_out;
  logic [8:0] ram_raddr_out;
  logic [7:0] ram_rdata_in;

  int checks = 0;
  int errors = 0;

  logic [7:0] mem [512];

  inbuf_ctrl dut (
    .clk_in        (clk_in),
    .rst_n_in      (rst_n_in),
    .rx_valid_in   (rx_valid_in),
    .rx_data_in    (rx_data_in),
    .pop_in        (pop_in),
    .clr_ovf_in    (clr_ovf_in),
    .data_out      (data_out),
    .valid_out     (valid_out),
    .count_out     (count_out),
    .full_out      (full_out),
    .overflow_out  (overflow_out),
    .ram_wen_out   (ram_wen_out),
    .ram_waddr_out (ram_waddr_out),
    .ram_wdata_out (ram_wdata_out),
    .ram_raddr_out (ram_raddr_out),
    .ram_rdata_in  (ram_rdata_in)
  );

  // BRAM model: registered read, old data returned on a same-address write.
  always @(posedge clk_in) begin
    if (ram_wen_out) mem[ram_waddr_out] <= ram_wdata_out;
    ram_rdata_in <= mem[ram_raddr_out];
  end

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  initial begin
    #900000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic tick();
    @(posedge clk_in);
    #1;
  endtask

  task automatic write_byte(input logic [7:0] b);
    rx_valid_in = 1'b1;
    rx_data_in  = b;
    tick();
    rx_valid_in = 1'b0;
  endtask

  task automatic do_reset();
    rx_valid_in = 1'b0;
    rx_data_in  = 8'h00;
    pop_in      = 1'b0;
    clr_ovf_in  = 1'b0;
    rst_n_in    = 1'b0;
    repeat (2) tick();
    rst_n_in = 1'b1;
    tick();
  endtask

  task automatic test_reset();
    do_reset();
    checks++;
    if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL reset_valid: got %b expected 0", valid_out); end
    checks++;
    if (data_out !== 8'h00) begin errors++; $display("[TB] FAIL reset_data: got %h expected 00", data_out); end
    checks++;
    if (count_out !== 10'd0) begin errors++; $display("[TB] FAIL reset_count: got %0d expected 0", count_out); end
    checks++;
    if (overflow_out !== 1'b0 || full_out !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_flags: got ovf=%b full=%b expected 0/0", overflow_out, full_out);
    end
  endtask

  task automatic test_single();
    do_reset();
    repeat (2) tick();
    write_byte(8'h41);
    checks++;
    if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL single_e0: got valid=%b expected 0", valid_out); end
    tick();
    checks++;
    if (valid_out !== 1'b0) begin errors++; $display("[TB] FAIL single_e1: got valid=%b expected 0", valid_out); end
    tick();
    checks++;
    if (valid_out !== 1'b1 || data_out !== 8'h41) begin
      errors++; $display("[TB] FAIL single_e2: got valid=%b data=%h expected 1/41", valid_out, data_out);
    end
    checks++;
    if (count_out !== 10'd0) begin errors++; $display("[TB] FAIL single_count: got %0d expected 0", count_out); end
    pop_in = 1'b1;
    tick();
    pop_in = 1'b0;
    tick();
    checks++;
    if (valid_out !== 1'b0 || count_out !== 10'd0) begin
      errors++; $display("[TB] FAIL single_pop: got valid=%b count=%0d expected 0/0", valid_out, count_out);
    end
  endtask

  task automatic test_burst();
    int k;
    int cyc;
    int lastCyc;
    do_reset();
    for (int i = 0; i < 10; i++) begin
      rx_valid_in = 1'b1;
      rx_data_in  = 8'(i);
      tick();
    end
    rx_valid_in = 1'b0;
    checks++;
    if (valid_out !== 1'b1 || data_out !== 8'h00 || count_out !== 10'd9) begin
      errors++; $display("[TB] FAIL burst_head: got valid=%b data=%h count=%0d expected 1/00/9", valid_out, data_out, count_out);
    end
    pop_in  = 1'b1;
    k       = 1;
    cyc     = 0;
    lastCyc = 0;
    while (k < 10 && cyc < 60) begin
      tick();
      cyc++;
      if (valid_out === 1'b1) begin
        checks++;
        if (data_out !== 8'(k)) begin errors++; $display("[TB] FAIL burst_order: got %h expected %h", data_out, 8'(k)); end
        checks++;
        if (cyc - lastCyc != 2) begin errors++; $display("[TB] FAIL burst_rate: got gap %0d expected 2", cyc - lastCyc); end
        lastCyc = cyc;
        k++;
      end
    end
    checks++;
    if (k != 10) begin errors++; $display("[TB] FAIL burst_timeout: got %0d bytes expected 9", k - 1); end
    tick();
    pop_in = 1'b0;
    tick();
    checks++;
    if (valid_out !== 1'b0 || count_out !== 10'd0) begin
      errors++; $display("[TB] FAIL burst_empty: got valid=%b count=%0d expected 0/0", valid_out, count_out);
    end
  endtask

  task automatic test_full();
    int k;
    int cyc;
    do_reset();
    for (int i = 0; i < 513; i++) begin
      rx_valid_in = 1'b1;
      rx_data_in  = 8'(i);
      tick();
    end
    rx_valid_in = 1'b0;
    tick();
    checks++;
    if (full_out !== 1'b1 || count_out !== 10'd512) begin
      errors++; $display("[TB] FAIL full_state: got full=%b count=%0d expected 1/512", full_out, count_out);
    end
    checks++;
    if (valid_out !== 1'b1 || data_out !== 8'h00) begin
      errors++; $display("[TB] FAIL full_head: got valid=%b data=%h expected 1/00", valid_out, data_out);
    end
    rx_valid_in = 1'b1;
    rx_data_in  = 8'hEE;
    #1;
    checks++;
    if (ram_wen_out !== 1'b0) begin errors++; $display("[TB] FAIL full_wen: got %b expected 0", ram_wen_out); end
    tick();
    rx_valid_in = 1'b0;
    checks++;
    if (overflow_out !== 1'b1 || count_out !== 10'd512) begin
      errors++; $display("[TB] FAIL overflow_set: got ovf=%b count=%0d expected 1/512", overflow_out, count_out);
    end
    rx_valid_in = 1'b1;
    clr_ovf_in  = 1'b1;
    tick();
    rx_valid_in = 1'b0;
    clr_ovf_in  = 1'b0;
    checks++;
    if (overflow_out !== 1'b1) begin errors++; $display("[TB] FAIL overflow_set_wins: got %b expected 1", overflow_out); end
    clr_ovf_in = 1'b1;
    tick();
    clr_ovf_in = 1'b0;
    checks++;
    if (overflow_out !== 1'b0) begin errors++; $display("[TB] FAIL overflow_clear: got %b expected 0", overflow_out); end
    pop_in = 1'b1;
    k      = 1;
    cyc    = 0;
    while (k < 513 && cyc < 1200) begin
      tick();
      cyc++;
      if (valid_out === 1'b1) begin
        checks++;
        if (data_out !== 8'(k)) begin errors++; $display("[TB] FAIL full_drain: got %h expected %h", data_out, 8'(k)); end
        k++;
      end
    end
    checks++;
    if (k != 513) begin errors++; $display("[TB] FAIL full_drain_timeout: got %0d bytes expected 512", k - 1); end
    tick();
    pop_in = 1'b0;
    tick();
    checks++;
    if (count_out !== 10'd0 || full_out !== 1'b0 || valid_out !== 1'b0) begin
      errors++; $display("[TB] FAIL full_drained: got count=%0d full=%b valid=%b expected 0/0/0", count_out, full_out, valid_out);
    end
  endtask

  task automatic test_same_edge();
    do_reset();
    write_byte(8'hA1);
    write_byte(8'hB2);
    tick();
    checks++;
    if (valid_out !== 1'b1 || data_out !== 8'hA1 || count_out !== 10'd1) begin
      errors++; $display("[TB] FAIL same_pre: got valid=%b data=%h count=%0d expected 1/a1/1", valid_out, data_out, count_out);
    end
    pop_in      = 1'b1;
    rx_valid_in = 1'b1;
    rx_data_in  = 8'hC3;
    tick();
    pop_in      = 1'b0;
    rx_valid_in = 1'b0;
    tick();
    checks++;
    if (valid_out !== 1'b1 || data_out !== 8'hB2 || count_out !== 10'd1) begin
      errors++; $display("[TB] FAIL same_mid: got valid=%b data=%h count=%0d expected 1/b2/1", valid_out, data_out, count_out);
    end
    pop_in = 1'b1;
    tick();
    pop_in = 1'b0;
    tick();
    checks++;
    if (valid_out !== 1'b1 || data_out !== 8'hC3 || count_out !== 10'd0) begin
      errors++; $display("[TB] FAIL same_last: got valid=%b data=%h count=%0d expected 1/c3/0", valid_out, data_out, count_out);
    end
  endtask

  task automatic test_wrap();
    logic [7:0] expQ[$];
    logic [7:0] want;
    int sent;
    int got;
    int cyc;
    do_reset();
    sent = 0;
    got  = 0;
    cyc  = 0;
    while (got < 1500 && cyc < 20000) begin
      pop_in = 1'b0;
      if (valid_out === 1'b1 && $urandom_range(0, 2) != 0) begin
        checks++;
        if (expQ.size() == 0) begin
          errors++; $display("[TB] FAIL wrap_extra: got %h expected no data", data_out);
        end else begin
          want = expQ.pop_front();
          if (data_out !== want) begin errors++; $display("[TB] FAIL wrap_data: got %h expected %h", data_out, want); end
        end
        pop_in = 1'b1;
        got++;
      end
      rx_valid_in = 1'b0;
      if (sent < 1500 && $urandom_range(0, 1) == 1) begin
        rx_valid_in = 1'b1;
        rx_data_in  = 8'((sent * 7) % 256);
        if (full_out === 1'b0) begin
          expQ.push_back(8'((sent * 7) % 256));
          sent++;
        end
      end
      tick();
      cyc++;
    end
    pop_in      = 1'b0;
    rx_valid_in = 1'b0;
    checks++;
    if (got != 1500) begin errors++; $display("[TB] FAIL wrap_timeout: got %0d bytes expected 1500", got); end
    repeat (3) tick();
    checks++;
    if (valid_out !== 1'b0 || count_out !== 10'd0 || expQ.size() != 0) begin
      errors++; $display("[TB] FAIL wrap_end: got valid=%b count=%0d left=%0d expected 0/0/0", valid_out, count_out, expQ.size());
    end
  endtask

  task automatic test_async_reset();
    do_reset();
    for (int i = 0; i < 6; i++) begin
      rx_valid_in = 1'b1;
      rx_data_in  = 8'(8'h10 + i);
      tick();
    end
    checks++;
    if (valid_out !== 1'b1 || count_out === 10'd0) begin
      errors++; $display("[TB] FAIL async_pre: got valid=%b count=%0d expected 1/nonzero", valid_out, count_out);
    end
    #2;
    rst_n_in = 1'b0;
    #1;
    checks++;
    if (valid_out !== 1'b0 || data_out !== 8'h00 || count_out !== 10'd0) begin
      errors++; $display("[TB] FAIL async_outputs: got valid=%b data=%h count=%0d expected 0/00/0", valid_out, data_out, count_out);
    end
    checks++;
    if (ram_wen_out !== 1'b0 || overflow_out !== 1'b0) begin
      errors++; $display("[TB] FAIL async_wen: got wen=%b ovf=%b expected 0/0", ram_wen_out, overflow_out);
    end
    rx_valid_in = 1'b0;
    tick();
    rst_n_in = 1'b1;
    tick();
    write_byte(8'h55);
    repeat (2) tick();
    checks++;
    if (valid_out !== 1'b1 || data_out !== 8'h55 || count_out !== 10'd0) begin
      errors++; $display("[TB] FAIL async_after: got valid=%b data=%h count=%0d expected 1/55/0", valid_out, data_out, count_out);
    end
  endtask

  initial begin
    rst_n_in    = 1'b0;
    rx_valid_in = 1'b0;
    rx_data_in  = 8'h00;
    pop_in      = 1'b0;
    clr_ovf_in  = 1'b0;
    test_reset();
    test_single();
    test_burst();
    test_full();
    test_same_edge();
    test_wrap();
    test_async_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
